// File: rtl/io_xbar_bus_compare_match.sv
// Masked multi-entry compare for io_xbar address/destination decode.
// One valid/ready output register carries the priority-encoded result and a saturating miss count.
module io_xbar_bus_compare_match #(
    parameter int WIDTH       = 8,
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_WIDTH   = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_we_i,
    input  logic [IDX_WIDTH-1:0]   cfg_idx_i,
    input  logic [WIDTH-1:0]       cfg_value_i,
    input  logic [WIDTH-1:0]       cfg_mask_i,
    input  logic                   cfg_en_i,
    input  logic                   in_val_i,
    input  logic [WIDTH-1:0]       in_data_i,
    output logic                   in_rdy_o,
    output logic                   out_val_o,
    input  logic                   out_rdy_i,
    output logic [WIDTH-1:0]       out_data_o,
    output logic                   out_hit_o,
    output logic [NUM_ENTRIES-1:0] out_hit_vec_o,
    output logic [IDX_WIDTH-1:0]   out_hit_idx_o,
    output logic [CNT_WIDTH-1:0]   miss_count_o
);

    logic [WIDTH-1:0]       value_q [NUM_ENTRIES];
    logic [WIDTH-1:0]       mask_q  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] en_q;

    logic                   out_val_q,  out_val_d;
    logic [WIDTH-1:0]       out_data_q, out_data_d;
    logic                   out_hit_q,  out_hit_d;
    logic [NUM_ENTRIES-1:0] out_vec_q,  out_vec_d;
    logic [IDX_WIDTH-1:0]   out_idx_q,  out_idx_d;
    logic [CNT_WIDTH-1:0]   miss_q,     miss_d;

    logic [NUM_ENTRIES-1:0] hit_vec;
    logic                   accept;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_WIDTH'(1);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] lowest_idx(input logic [NUM_ENTRIES-1:0] v);
        logic [IDX_WIDTH-1:0] r;
        r = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_WIDTH'(i);
            end
        end
        return r;
    endfunction

    // Out-of-range cfg_idx never equals any entry number, so it is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                value_q[i] <= '0;
                mask_q[i]  <= '1;
                en_q[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cfg_we_i && (cfg_idx_i == IDX_WIDTH'(i))) begin
                    value_q[i] <= cfg_value_i;
                    mask_q[i]  <= cfg_mask_i;
                    en_q[i]    <= cfg_en_i;
                end
            end
        end
    end

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hit_vec[i] = en_q[i] && (((in_data_i ^ value_q[i]) & mask_q[i]) == '0);
        end
    end

    assign in_rdy_o = !out_val_q || out_rdy_i;
    assign accept   = in_val_i && in_rdy_o;

    always_comb begin
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        out_hit_d  = out_hit_q;
        out_vec_d  = out_vec_q;
        out_idx_d  = out_idx_q;
        miss_d     = miss_q;
        if (accept) begin
            out_val_d  = 1'b1;
            out_data_d = in_data_i;
            out_hit_d  = |hit_vec;
            out_vec_d  = hit_vec;
            out_idx_d  = lowest_idx(hit_vec);
            if (!(|hit_vec)) begin
                miss_d = sat_inc(miss_q);
            end
        end else if (out_rdy_i) begin
            out_val_d = 1'b0;
        end
    end

    // Output register stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            out_hit_q  <= 1'b0;
            out_vec_q  <= '0;
            out_idx_q  <= '0;
            miss_q     <= '0;
        end else begin
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            out_hit_q  <= out_hit_d;
            out_vec_q  <= out_vec_d;
            out_idx_q  <= out_idx_d;
            miss_q     <= miss_d;
        end
    end

    assign out_val_o     = out_val_q;
    assign out_data_o    = out_data_q;
    assign out_hit_o     = out_hit_q;
    assign out_hit_vec_o = out_vec_q;
    assign out_hit_idx_o = out_idx_q;
    assign miss_count_o  = miss_q;

endmodule
